shift_register_piso: RTL and testbench

- Parallel-in, serial-out shift register. A WIDTH-bit word is captured on a load cycle, then shifted out one bit per Clk cycle on Serial_Out.
- Used as a simple serializer between a parallel datapath and a one-bit serial link.
- Provides a valid/busy indication so downstream logic knows which Serial_Out bits carry loaded data.

---
 rtl/shift_register_piso.sv | 59 +++++
 tb/tb_shift_register_piso.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out shift register with a valid/busy flag.
// The word is loaded in one cycle, then shifted out one bit per Clk; the vacated end fills with FILL.
module shift_register_piso #(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic FILL      = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Parallel_In,
  input  logic             load,
  output logic             Serial_Out,
  output logic             Serial_Valid,
  output logic             Busy
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], FILL};
      assign Serial_Out = shift_reg[WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next = {FILL, shift_reg[WIDTH-1:1]};
      assign Serial_Out = shift_reg[0];
    end
  endgenerate

  // Counter saturates at zero so the idle FILL stream never looks valid.
  always_comb begin
    cnt_next = bit_cnt;
    if (bit_cnt != '0) begin
      cnt_next = bit_cnt - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= Parallel_In;
      bit_cnt   <= CNT_FULL;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
    end
  end

  assign Serial_Valid = (bit_cnt != '0);
  assign Busy         = Serial_Valid;

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: an LSB-first/FILL=0 and an MSB-first/FILL=1 instance share stimulus.
// Hand-written vectors cover the corner sequences; a random phase runs against a bit-queue model.
module tb_shift_register_piso;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] pin;
  logic       out_l, val_l, busy_l;
  logic       out_m, val_m, busy_m;

  shift_register_piso #(.WIDTH(4), .MSB_FIRST(1'b0), .FILL(1'b0)) u_lsb (
    .Clk(clk), .Rst_n(rst_n), .Parallel_In(pin), .load(load),
    .Serial_Out(out_l), .Serial_Valid(val_l), .Busy(busy_l)
  );

  shift_register_piso #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL(1'b1)) u_msb (
    .Clk(clk), .Rst_n(rst_n), .Parallel_In(pin), .load(load),
    .Serial_Out(out_m), .Serial_Valid(val_m), .Busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n;
    bit         load;
    logic [3:0] pin;
    bit         out;
    bit         valid;
  } vec_t;

  typedef struct {
    bit out_l;
    bit val_l;
    bit out_m;
    bit val_m;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: bits in the order they will appear on Serial_Out; index 0 is the current bit.
  bit m_bits[2][4];
  int m_cnt[2];

  task automatic add(input bit r, input bit l, input logic [3:0] p, input bit o, input bit v);
    vec_t e;
    e.rst_n = r; e.load = l; e.pin = p; e.out = o; e.valid = v;
    tbl.push_back(e);
  endtask

  task automatic model_step(input int k, input bit r, input bit l, input logic [3:0] w);
    bit fill;
    fill = (k == 1);
    if (!r) begin
      for (int i = 0; i < 4; i++) m_bits[k][i] = 1'b0;
      m_cnt[k] = 0;
    end else if (l) begin
      for (int i = 0; i < 4; i++) m_bits[k][i] = (k == 1) ? w[3-i] : w[i];
      m_cnt[k] = 4;
    end else begin
      for (int i = 0; i < 3; i++) m_bits[k][i] = m_bits[k][i+1];
      m_bits[k][3] = fill;
      if (m_cnt[k] > 0) m_cnt[k]--;
    end
  endtask

  task automatic chk(input string name, input int cyc, input logic act, input bit exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic run_cycle(input int cyc, input bit r, input bit l, input logic [3:0] p,
                           input bit use_tbl, input bit t_out, input bit t_val);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n = r; load = l; pin = p;
    model_step(0, r, l, p);
    model_step(1, r, l, p);
    e.out_l = use_tbl ? t_out : m_bits[0][0];
    e.val_l = use_tbl ? t_val : (m_cnt[0] != 0);
    e.out_m = m_bits[1][0];
    e.val_m = (m_cnt[1] != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("lsb_out",   cyc, out_l,  g.out_l);
    chk("lsb_valid", cyc, val_l,  g.val_l);
    chk("lsb_busy",  cyc, busy_l, g.val_l);
    chk("msb_out",   cyc, out_m,  g.out_m);
    chk("msb_valid", cyc, val_m,  g.val_m);
    chk("msb_busy",  cyc, busy_m, g.val_m);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; pin = 4'h0;

    // Reset beats load.
    add(0, 1, 4'b1111, 0, 0);
    add(0, 1, 4'b1111, 0, 0);
    // Basic LSB-first: 0101 -> 1,0,1,0 then idle 0; Parallel_In changes ignored.
    add(1, 1, 4'b0101, 1, 1);
    add(1, 0, 4'b1111, 0, 1);
    add(1, 0, 4'b1010, 1, 1);
    add(1, 0, 4'bxxxx, 0, 1);
    add(1, 0, 4'b1111, 0, 0);
    add(1, 0, 4'bxxxx, 0, 0);
    // Reload mid-shift: 1,0 then 0110 -> 0,1,1,0 with valid held.
    add(1, 1, 4'b0101, 1, 1);
    add(1, 0, 4'b0000, 0, 1);
    add(1, 1, 4'b0110, 0, 1);
    add(1, 0, 4'b0000, 1, 1);
    add(1, 0, 4'b0000, 1, 1);
    add(1, 0, 4'b0000, 0, 1);
    add(1, 0, 4'b0000, 0, 0);
    // Held load reloads every cycle.
    add(1, 1, 4'b0110, 0, 1);
    add(1, 1, 4'b0110, 0, 1);
    add(1, 1, 4'b0110, 0, 1);
    add(1, 0, 4'b0000, 1, 1);
    add(1, 0, 4'b0000, 1, 1);
    add(1, 0, 4'b0000, 0, 1);
    add(1, 0, 4'b0000, 0, 0);
    // Reset mid-shift: 1011 -> 1,1 then reset; stays idle.
    add(1, 1, 4'b1011, 1, 1);
    add(1, 0, 4'b0000, 1, 1);
    add(0, 0, 4'b0000, 0, 0);
    add(1, 0, 4'b1111, 0, 0);
    add(1, 0, 4'b1111, 0, 0);
    // Reset beats load in the middle of a word.
    add(1, 1, 4'b1001, 1, 1);
    add(0, 1, 4'b1001, 0, 0);
    add(1, 0, 4'b0000, 0, 0);
    // Drain so the FILL=1 stream of the MSB instance is exercised.
    add(1, 0, 4'b0000, 0, 0);
    add(1, 0, 4'b0000, 0, 0);
    add(1, 0, 4'b0000, 0, 0);
    add(1, 0, 4'b0000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(i, tbl[i].rst_n, tbl[i].load, tbl[i].pin, 1'b1, tbl[i].out, tbl[i].valid);
    end

    for (int i = 0; i < 300; i++) begin
      bit         r;
      bit         l;
      logic [3:0] p;
      r = ($urandom_range(0, 29) != 0);
      l = ($urandom_range(0, 5) == 0);
      p = 4'($urandom_range(0, 15));
      run_cycle(1000 + i, r, l, p, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
